// File: rtl/decoder_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : decoder_rr_arbiter
// Brief    : N-way round-robin / fixed-priority arbiter with a forced-decode path
//            that issues a registered one-hot grant plus its binary index.
// Revision : 1.0 - initial release
// ============================================================================
module decoder_rr_arbiter #(
    parameter int K          = 3,
    parameter bit RR_DEFAULT = 1'b1
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_i,
    input  logic [2**K-1:0]   req_i,
    input  logic              done_i,
    input  logic              mode_wr_i,
    input  logic              mode_i,
    input  logic              force_en_i,
    input  logic [K-1:0]      force_idx_i,
    output logic [2**K-1:0]   grant_o,
    output logic [K-1:0]      grant_idx_o,
    output logic              grant_valid_o,
    output logic              forced_o
);

    localparam int N = 2**K;

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_GRANT = 1'b1
    } state_t;

    state_t         r_state;
    state_t         w_next_state;
    logic [N-1:0]   r_grant;
    logic [N-1:0]   w_next_grant;
    logic [K-1:0]   r_idx;
    logic [K-1:0]   w_next_idx;
    logic           r_forced;
    logic           w_next_forced;
    logic [K-1:0]   r_ptr;
    logic [K-1:0]   w_next_ptr;
    logic           r_mode;

    logic [K-1:0]   w_rr_idx;
    logic [K-1:0]   w_fx_idx;
    logic [K-1:0]   w_cand;
    logic [K-1:0]   w_win_idx;
    logic           w_any_req;
    logic           w_arb;

    // Scanning offsets from N down to 1 leaves the closest requester after the
    // pointer as the final assignment; offset N wraps to the pointer itself.
    always_comb begin
        w_rr_idx = '0;
        w_cand   = '0;
        for (int i = N; i >= 1; i--) begin
            w_cand = r_ptr + K'(i);
            if (req_i[w_cand]) begin
                w_rr_idx = w_cand;
            end
        end
    end

    always_comb begin
        w_fx_idx = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req_i[i]) begin
                w_fx_idx = K'(i);
            end
        end
    end

    assign w_any_req = |req_i;
    assign w_win_idx = r_mode ? w_rr_idx : w_fx_idx;
    assign w_arb     = (r_state == S_IDLE) || done_i;

    always_comb begin
        w_next_state  = r_state;
        w_next_grant  = r_grant;
        w_next_idx    = r_idx;
        w_next_forced = r_forced;
        w_next_ptr    = r_ptr;
        if (w_arb) begin
            if (force_en_i) begin
                w_next_state  = S_GRANT;
                w_next_idx    = force_idx_i;
                w_next_grant  = N'(1) << force_idx_i;
                w_next_forced = 1'b1;
            end else if (w_any_req) begin
                w_next_state  = S_GRANT;
                w_next_idx    = w_win_idx;
                w_next_grant  = N'(1) << w_win_idx;
                w_next_forced = 1'b0;
                w_next_ptr    = w_win_idx;
            end else begin
                w_next_state  = S_IDLE;
                w_next_idx    = '0;
                w_next_grant  = '0;
                w_next_forced = 1'b0;
            end
        end
    end

    // Mode writes land at the edge, so the arbitration on that same edge
    // still sees the previous mode.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_state  <= S_IDLE;
            r_grant  <= '0;
            r_idx    <= '0;
            r_forced <= 1'b0;
            r_ptr    <= K'(N - 1);
            r_mode   <= RR_DEFAULT;
        end else begin
            r_state  <= w_next_state;
            r_grant  <= w_next_grant;
            r_idx    <= w_next_idx;
            r_forced <= w_next_forced;
            r_ptr    <= w_next_ptr;
            if (mode_wr_i) begin
                r_mode <= mode_i;
            end
        end
    end

    assign grant_o       = r_grant;
    assign grant_idx_o   = r_idx;
    assign grant_valid_o = |r_grant;
    assign forced_o      = r_forced;

endmodule
`default_nettype wire

// File: tb/tb_decoder_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_decoder_rr_arbiter
// Brief    : Directed plus randomized bench for decoder_rr_arbiter against a
//            behavioural model of the arbitration rules.
// Revision : 1.0 - initial release
// ============================================================================
module tb_decoder_rr_arbiter;

    localparam int K = 3;
    localparam int N = 2**K;

    logic           clk;
    logic           rst;
    logic [N-1:0]   req;
    logic           done;
    logic           mode_wr;
    logic           mode;
    logic           fen;
    logic [K-1:0]   fidx;
    logic [N-1:0]   grant;
    logic [K-1:0]   grant_idx;
    logic           grant_valid;
    logic           forced;

    int total_checks;
    int passed_checks;
    int failed_checks;

    // Reference model state
    bit m_valid;
    bit m_forced;
    bit m_mode;
    int m_idx;
    int m_ptr;

    decoder_rr_arbiter #(.K(K), .RR_DEFAULT(1'b1)) u_dut (
        .wb_clk_i      (clk),
        .wb_rst_i      (rst),
        .req_i         (req),
        .done_i        (done),
        .mode_wr_i     (mode_wr),
        .mode_i        (mode),
        .force_en_i    (fen),
        .force_idx_i   (fidx),
        .grant_o       (grant),
        .grant_idx_o   (grant_idx),
        .grant_valid_o (grant_valid),
        .forced_o      (forced)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total_checks++;
        assert (got === exp) passed_checks++;
        else begin
            failed_checks++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance the model by one clock edge from the inputs currently applied.
    task automatic model_edge();
        int c;
        if (rst) begin
            m_valid  = 0;
            m_forced = 0;
            m_idx    = 0;
            m_ptr    = N - 1;
            m_mode   = 1;
        end else begin
            if (!m_valid || done) begin
                if (fen) begin
                    m_valid  = 1;
                    m_forced = 1;
                    m_idx    = int'(fidx);
                end else if (req != 0) begin
                    m_valid  = 1;
                    m_forced = 0;
                    if (m_mode) begin
                        for (int off = 1; off <= N; off++) begin
                            c = (m_ptr + off) % N;
                            if (req[c]) begin
                                m_idx = c;
                                break;
                            end
                        end
                    end else begin
                        for (int j = 0; j < N; j++) begin
                            if (req[j]) begin
                                m_idx = j;
                                break;
                            end
                        end
                    end
                    m_ptr = m_idx;
                end else begin
                    m_valid  = 0;
                    m_forced = 0;
                    m_idx    = 0;
                end
            end
            if (mode_wr) m_mode = mode;
        end
    endtask

    task automatic step(input string tag);
        logic [N-1:0] exp_grant;
        model_edge();
        @(posedge clk);
        #1;
        exp_grant = m_valid ? (N'(1) << m_idx) : '0;
        chk({tag, ".grant"},  32'(grant),       32'(exp_grant));
        chk({tag, ".idx"},    32'(grant_idx),   32'(m_idx));
        chk({tag, ".valid"},  32'(grant_valid), 32'(m_valid));
        chk({tag, ".forced"}, 32'(forced),      32'(m_forced));
    endtask

    task automatic drive(input logic r, input logic [N-1:0] rq, input logic d,
                         input logic mw, input logic md, input logic fe, input logic [K-1:0] fi);
        rst = r; req = rq; done = d; mode_wr = mw; mode = md; fen = fe; fidx = fi;
    endtask

    initial begin
        total_checks  = 0;
        passed_checks = 0;
        failed_checks = 0;
        m_valid = 0; m_forced = 0; m_idx = 0; m_ptr = N - 1; m_mode = 1;

        // Reset then idle
        drive(1, 8'h00, 0, 0, 0, 0, 0);
        step("rst0");
        step("rst1");
        drive(0, 8'h00, 0, 0, 0, 0, 0);
        step("idle0");
        step("idle1");

        // Round-robin wrap: two full laps ending with ptr at 7
        drive(0, 8'hFF, 1, 0, 0, 0, 0);
        for (int i = 0; i < 2 * N; i++) begin
            step("rr_ff");
            chk("rr_seq", 32'(grant_idx), 32'(i % N));
        end
        drive(0, 8'h81, 1, 0, 0, 0, 0);
        step("rr81a"); chk("rr81_0", 32'(grant_idx), 32'd0);
        step("rr81b"); chk("rr81_7", 32'(grant_idx), 32'd7);
        step("rr81c"); chk("rr81_0b", 32'(grant_idx), 32'd0);

        // Fixed priority
        drive(0, 8'hA4, 0, 1, 0, 0, 0);
        step("mode_fx");
        drive(0, 8'hA4, 1, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            step("fx_a4");
            chk("fx_2", 32'(grant_idx), 32'd2);
        end
        drive(0, 8'hA0, 1, 0, 0, 0, 0);
        step("fx_a0"); chk("fx_5", 32'(grant_idx), 32'd5);

        // Force path in round-robin mode, from IDLE
        drive(0, 8'h00, 1, 1, 1, 0, 0);
        step("to_idle");
        drive(0, 8'h10, 0, 0, 0, 1, 3'd6);
        step("force6");
        chk("force_grant", 32'(grant), 32'h40);
        chk("force_flag", 32'(forced), 32'd1);
        drive(0, 8'h10, 1, 0, 0, 0, 0);
        step("after_force");
        chk("after_force_idx", 32'(grant_idx), 32'd4);

        // Hold and release
        drive(0, 8'h08, 1, 0, 0, 0, 0);
        step("grant3");
        drive(0, 8'h00, 0, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) begin
            step("hold3");
            chk("hold_grant", 32'(grant), 32'h08);
        end
        drive(0, 8'h00, 1, 0, 0, 0, 0);
        step("release");
        chk("release_valid", 32'(grant_valid), 32'd0);
        drive(0, 8'h00, 1, 0, 0, 0, 0);
        step("idle_done");

        // Reset mid-grant
        drive(0, 8'h20, 0, 0, 0, 0, 0);
        step("grant5");
        drive(1, 8'h20, 0, 0, 0, 0, 0);
        step("rst_mid");
        chk("rst_mid_grant", 32'(grant), 32'h00);
        drive(0, 8'hFF, 0, 0, 0, 0, 0);
        step("post_rst");
        chk("post_rst_idx", 32'(grant_idx), 32'd0);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            drive(($urandom_range(0, 99) < 2),
                  ($urandom_range(0, 3) == 0) ? 8'h00 : N'($urandom),
                  $urandom_range(0, 1) == 1,
                  ($urandom_range(0, 99) < 6),
                  $urandom_range(0, 1) == 1,
                  ($urandom_range(0, 99) < 10),
                  K'($urandom));
            step("rand");
        end

        $display("%0d/%0d checks passed", passed_checks, total_checks);
        $finish;
    end

endmodule
`default_nettype wire
